mult16_engine: RTL and testbench
================================

MULT16_ENGINE -- requirements
Module: mult16_engine

Interface
REQ-001 Parameter IN_BASE, default 0: byte address of first operand pair.
REQ-002 Parameter OUT_BASE, default 64: byte address of first product.
REQ-003 Parameter NPAIRS, default 16: operand pairs processed per request.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-006 req  input  1  start request from host; a 0->1 transition starts a run.
REQ-007 done  output  1  run complete; registered.
REQ-008 mem_addr  output  8  byte address to data memory.
REQ-009 mem_rdata  input  8  read data; combinational from mem_addr in the same cycle.
REQ-010 mem_wdata  output  8  write data.
REQ-011 mem_wen  output  1  write strobe; memory writes mem_wdata at mem_addr on the rising edge while high.

Function
REQ-012 Pair p (0..NPAIRS-1): A = {mem[IN_BASE+4p], mem[IN_BASE+4p+1]}, B = {mem[IN_BASE+4p+2], mem[IN_BASE+4p+3]}, both signed 16-bit, high byte first.
REQ-013 Product P = A*B, signed 32-bit, exact for all inputs including -32768*-32768 = 0x40000000.
REQ-014 P is written big-endian to OUT_BASE+4p .. OUT_BASE+4p+3, high byte first.
REQ-015 States: IDLE, LOAD, MUL, STORE, DONE.
REQ-016 IDLE: done=0, mem_wen=0; go to LOAD with p=0 when req=1 and the registered previous req=0.
REQ-017 LOAD, 4 cycles, k=0..3: mem_addr=IN_BASE+4p+k; capture mem_rdata into A/B byte k; then go to MUL.
REQ-018 MUL, 16 cycles: unsigned shift-add on |A| and |B|, 17-bit magnitudes, one multiplier bit per cycle, LSB first.
REQ-019 At MUL exit, the 32-bit result is negated when sign(A) XOR sign(B) and the magnitude product is nonzero.
REQ-020 STORE, 4 cycles, k=0..3: mem_wen=1, mem_addr=OUT_BASE+4p+k, mem_wdata=P[31-8k:24-8k].
REQ-021 After STORE: if p<NPAIRS-1, increment p and go to LOAD; otherwise go to DONE.
REQ-022 Each pair takes exactly 24 cycles; default run latency is 384 cycles.
REQ-023 done rises on the 384th rising edge after the edge that samples the req rise.
REQ-024 DONE: done=1 and held; mem_wen=0; a new req 0->1 edge goes to LOAD with p=0, and done drops on that edge.
REQ-025 A req edge while in LOAD, MUL or STORE is ignored; the run is not restarted.
REQ-026 mem_wen is 0 in every state except STORE; no memory outside the OUT_BASE product region is written.
REQ-027 Address arithmetic is 8-bit and wraps modulo 256; no range check is performed.

Reset
REQ-028 reset=0 at any rising edge forces IDLE, p=0, A/B/P=0, registered previous req=1, done=0, mem_wen=0, mem_addr=0, mem_wdata=0.
REQ-029 Reset mid-run aborts immediately; partially written products are left as is.
REQ-030 After release, a req already held high does not start a run; a fresh 0->1 edge is required.

Verification
REQ-031 Single pair A=3, B=-2, NPAIRS=1 -> bytes 64..67 = FF FF FF FA; done high 24 edges after the req edge.
REQ-032 Extremes: pair0 -32768*-32768 -> 40 00 00 00; pair1 32767*-32768 -> C0 00 80 00; pair2 0*-5 -> 00 00 00 00; pair3 -1*-1 -> 00 00 00 01.
REQ-033 Full 16 random pairs -> all products match the reference model; done at edge 384 exactly; no write outside 64..127.
REQ-034 Second req pulse at cycle 100 of a run -> no restart; done still at edge 384.
REQ-035 reset=0 at cycle 50 -> next cycle done=0, mem_wen=0, state IDLE; a new req edge then runs a full 384-cycle pass with correct results.
REQ-036 After done, req held high with no new edge -> done stays 1 and no memory writes occur for 100 cycles.

Source files
------------

// File: rtl/mult16_engine.sv
// Signed 16x16 multiply engine: streams NPAIRS operand pairs out of byte memory,
// multiplies each with a 16-step shift-add on magnitudes, and writes 32-bit products back.
module mult16_engine #(
    parameter int IN_BASE  = 0,
    parameter int OUT_BASE = 64,
    parameter int NPAIRS   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    output logic       done,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rdata,
    output logic [7:0] mem_wdata,
    output logic       mem_wen
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MUL,
        S_STORE,
        S_DONE
    } state_t;

    localparam logic [7:0] IN_B      = 8'(IN_BASE);
    localparam logic [7:0] OUT_B     = 8'(OUT_BASE);
    localparam logic [7:0] LAST_PAIR = 8'(NPAIRS - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  pair_q, pair_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        neg_q, neg_d;
    logic [31:0] mcand_q, mcand_d;
    logic [16:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] prod_q, prod_d;
    logic        req_prev_q, req_prev_d;
    logic        done_q, done_d;

    logic        req_rise;
    logic [7:0]  pair_off;
    logic [15:0] b_full;
    logic [16:0] a_ext, b_ext, a_mag, b_mag;
    logic [31:0] acc_sum;

    assign req_rise = req & ~req_prev_q;
    assign pair_off = {pair_q[5:0], 2'b00};
    // The low byte of B arrives on the last LOAD cycle, so the magnitudes are formed from it directly.
    assign b_full   = {b_q[15:8], mem_rdata};
    assign a_ext    = {a_q[15], a_q};
    assign b_ext    = {b_full[15], b_full};
    assign a_mag    = a_q[15] ? (~a_ext + 17'd1) : a_ext;
    assign b_mag    = b_full[15] ? (~b_ext + 17'd1) : b_ext;
    assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
    assign done     = done_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pair_d     = pair_q;
        a_d        = a_q;
        b_d        = b_q;
        neg_d      = neg_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        prod_d     = prod_q;
        done_d     = done_q;
        req_prev_d = req;
        mem_addr   = 8'd0;
        mem_wdata  = 8'd0;
        mem_wen    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (req_rise) begin
                    state_d = S_LOAD;
                    cnt_d   = 4'd0;
                    pair_d  = 8'd0;
                    done_d  = 1'b0;
                end
            end
            S_LOAD: begin
                mem_addr = IN_B + pair_off + {6'd0, cnt_q[1:0]};
                case (cnt_q[1:0])
                    2'd0:    a_d[15:8] = mem_rdata;
                    2'd1:    a_d[7:0]  = mem_rdata;
                    2'd2:    b_d[15:8] = mem_rdata;
                    default: b_d[7:0]  = mem_rdata;
                endcase
                cnt_d = cnt_q + 4'd1;
                if (cnt_q[1:0] == 2'd3) begin
                    state_d  = S_MUL;
                    cnt_d    = 4'd0;
                    neg_d    = a_q[15] ^ b_full[15];
                    mcand_d  = {15'd0, a_mag};
                    mplier_d = b_mag;
                    acc_d    = 32'd0;
                end
            end
            S_MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = S_STORE;
                    cnt_d   = 4'd0;
                    prod_d  = (neg_q && acc_sum != 32'd0) ? (~acc_sum + 32'd1) : acc_sum;
                end
            end
            S_STORE: begin
                mem_wen  = 1'b1;
                mem_addr = OUT_B + pair_off + {6'd0, cnt_q[1:0]};
                case (cnt_q[1:0])
                    2'd0:    mem_wdata = prod_q[31:24];
                    2'd1:    mem_wdata = prod_q[23:16];
                    2'd2:    mem_wdata = prod_q[15:8];
                    default: mem_wdata = prod_q[7:0];
                endcase
                cnt_d = cnt_q + 4'd1;
                if (cnt_q[1:0] == 2'd3) begin
                    cnt_d = 4'd0;
                    if (pair_q == LAST_PAIR) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        pair_d  = pair_q + 8'd1;
                        state_d = S_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Previous req resets high so a request already asserted at release cannot start a run.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            pair_q     <= 8'd0;
            a_q        <= 16'd0;
            b_q        <= 16'd0;
            neg_q      <= 1'b0;
            mcand_q    <= 32'd0;
            mplier_q   <= 17'd0;
            acc_q      <= 32'd0;
            prod_q     <= 32'd0;
            req_prev_q <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pair_q     <= pair_d;
            a_q        <= a_d;
            b_q        <= b_d;
            neg_q      <= neg_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            prod_q     <= prod_d;
            req_prev_q <= req_prev_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_mult16_engine.sv
// Self-checking bench for mult16_engine: byte memory model, product table and a write scoreboard.
module tb_mult16_engine;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req = 1'b1;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic [7:0] mem_wdata;
    logic       mem_wen;

    logic       tb_we = 1'b0;
    logic [7:0] tb_addr = 8'd0;
    logic [7:0] tb_data = 8'd0;
    logic [7:0] mem [256];

    int n_checks = 0;
    int n_fails  = 0;
    int n_writes = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    vec_t tbl [16];
    wr_t  sb [$];
    wr_t  sb_head;

    mult16_engine dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_wdata (mem_wdata),
        .mem_wen   (mem_wen)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    // Single write process for the memory; the bench preloads through its own port.
    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_wdata;
        if (tb_we)   mem[tb_addr]  <= tb_data;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Every DUT write must match the next expected byte and land in the product region.
    always @(negedge clk) begin
        if (reset && mem_wen) begin
            n_writes++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("[TB] FAIL unexpected_write: got addr 0x%02h data 0x%02h, expected no write",
                         mem_addr, mem_wdata);
            end else begin
                sb_head = sb.pop_front();
                checkOutput("wr_addr", 32'(mem_addr), 32'(sb_head.addr));
                checkOutput("wr_data", 32'(mem_wdata), 32'(sb_head.data));
            end
            checkOutput("wr_in_range", 32'(mem_addr >= 8'd64 && mem_addr <= 8'd127), 32'd1);
        end
    end

    task automatic memPoke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_we   = 1'b1;
        tb_addr = a;
        tb_data = d;
    endtask

    task automatic genTable(input bit with_fixed);
        int sa, sb_v;
        for (int i = 0; i < 16; i++) begin
            tbl[i].a = 16'($urandom);
            tbl[i].b = 16'($urandom);
            sa       = int'($signed(tbl[i].a));
            sb_v     = int'($signed(tbl[i].b));
            tbl[i].p = 32'(sa * sb_v);
        end
        if (with_fixed) begin
            tbl[0] = '{16'h0003, 16'hFFFE, 32'hFFFF_FFFA};
            tbl[1] = '{16'h8000, 16'h8000, 32'h4000_0000};
            tbl[2] = '{16'h7FFF, 16'h8000, 32'hC000_8000};
            tbl[3] = '{16'h0000, 16'hFFFB, 32'h0000_0000};
            tbl[4] = '{16'hFFFF, 16'hFFFF, 32'h0000_0001};
        end
    endtask

    // Loads operands, poisons the product region, queues expected writes, then raises req.
    task automatic applyStimulus();
        wr_t w;
        for (int p = 0; p < 16; p++) begin
            memPoke(8'(4 * p),     tbl[p].a[15:8]);
            memPoke(8'(4 * p + 1), tbl[p].a[7:0]);
            memPoke(8'(4 * p + 2), tbl[p].b[15:8]);
            memPoke(8'(4 * p + 3), tbl[p].b[7:0]);
        end
        for (int i = 0; i < 64; i++) memPoke(8'(64 + i), 8'hA5);
        @(negedge clk);
        tb_we = 1'b0;
        for (int p = 0; p < 16; p++) begin
            for (int k = 0; k < 4; k++) begin
                w.addr = 8'(64 + 4 * p + k);
                w.data = tbl[p].p[31 - 8 * k -: 8];
                sb.push_back(w);
            end
        end
        req = 1'b0;
        @(negedge clk);
        req = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("done_low_after_req_edge", 32'(done), 32'd0);
    endtask

    task automatic runToDone(input bit second_pulse);
        int cycles;
        bit got;
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles < 600) begin
            @(posedge clk);
            #1;
            cycles++;
            if (second_pulse && cycles == 100) req = 1'b0;
            if (second_pulse && cycles == 102) req = 1'b1;
            if (done) got = 1'b1;
        end
        checkOutput("done_latency", 32'(cycles), 32'd384);
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic checkResults();
        logic [31:0] got;
        for (int p = 0; p < 16; p++) begin
            got = {mem[8'(64 + 4 * p)], mem[8'(65 + 4 * p)],
                   mem[8'(66 + 4 * p)], mem[8'(67 + 4 * p)]};
            checkOutput($sformatf("product[%0d]", p), got, tbl[p].p);
        end
    endtask

    initial begin
        int w0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_wen", 32'(mem_wen), 32'd0);
        checkOutput("rst_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_wdata", 32'(mem_wdata), 32'd0);

        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checkOutput("held_req_no_start", 32'(mem_addr), 32'd0);
        end
        checkOutput("held_req_done", 32'(done), 32'd0);

        $display("[TB] run 1: fixed corner pairs plus random pairs");
        genTable(1'b1);
        applyStimulus();
        runToDone(1'b0);
        checkResults();

        $display("[TB] run 2: restart from DONE with an ignored req pulse at cycle 100");
        genTable(1'b0);
        applyStimulus();
        runToDone(1'b1);
        checkResults();

        $display("[TB] run 3: reset at cycle 50, then a fresh full run");
        genTable(1'b0);
        applyStimulus();
        repeat (50) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_wen", 32'(mem_wen), 32'd0);
        checkOutput("abort_addr", 32'(mem_addr), 32'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("abort_held_req_no_start", 32'(mem_addr), 32'd0);
        end
        genTable(1'b0);
        applyStimulus();
        runToDone(1'b0);
        checkResults();

        $display("[TB] hold req high after done");
        w0 = n_writes;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            checkOutput("done_hold", 32'(done), 32'd1);
        end
        checkOutput("no_writes_after_done", 32'(n_writes - w0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
